// File: rtl/fir_stim_gen.sv
// Burst sample source for the FIR datapath: impulse, step, PRBS9 or alternating
// +/-0.5 samples at a programmable rate, each paired with a one-cycle enable strobe.
module fir_stim_gen #(
    parameter int unsigned NB_DATA  = 8,
    parameter int unsigned NBF_DATA = 7,
    parameter int unsigned NB_DIV   = 8,
    parameter int unsigned NB_CNT   = 16
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [1:0]          i_mode,
    input  logic [NB_DIV-1:0]   i_div,
    input  logic [NB_CNT-1:0]   i_nsamp,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_en,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_IMPULSE,
        MODE_STEP,
        MODE_PRBS,
        MODE_ALT
    } mode_e;

    localparam logic [8:0]         LFSR_SEED = 9'h1FF;
    localparam logic [NB_DATA-1:0] MAX_POS   = NB_DATA'((1 << NBF_DATA) - 1);
    localparam logic [NB_DATA-1:0] HALF_POS  = NB_DATA'(1 << (NBF_DATA - 1));
    localparam logic [NB_DATA-1:0] HALF_NEG  = '0 - HALF_POS;

    state_e              state_q,   state_d;
    mode_e               mode_q,    mode_d;
    logic [NB_DIV-1:0]   div_l_q,   div_l_d;
    logic [NB_CNT-1:0]   nsamp_l_q, nsamp_l_d;
    logic [NB_DIV-1:0]   div_cnt_q, div_cnt_d;
    logic [NB_CNT-1:0]   cnt_q,     cnt_d;
    logic [8:0]          lfsr_q,    lfsr_d;
    logic                stop_q,    stop_d;
    logic [NB_DATA-1:0]  data_q,    data_d;
    logic                en_q,      en_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [NB_DATA-1:0]  sample_val;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_IMPULSE;
            div_l_q   <= '0;
            nsamp_l_q <= '0;
            div_cnt_q <= '0;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            stop_q    <= 1'b0;
            data_q    <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_l_q   <= div_l_d;
            nsamp_l_q <= nsamp_l_d;
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            stop_q    <= stop_d;
            data_q    <= data_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Waveform value for sample index cnt_q of the current burst.
    always_comb begin
        sample_val = '0;
        case (mode_q)
            MODE_IMPULSE: sample_val = (cnt_q == '0) ? MAX_POS : '0;
            MODE_STEP:    sample_val = MAX_POS;
            MODE_PRBS:    sample_val = lfsr_q[NB_DATA-1:0];
            MODE_ALT:     sample_val = cnt_q[0] ? HALF_NEG : HALF_POS;
            default:      sample_val = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_l_d   = div_l_q;
        nsamp_l_d = nsamp_l_q;
        div_cnt_d = div_cnt_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        stop_d    = stop_q;
        data_d    = data_q;
        en_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_RUN;
                    mode_d    = mode_e'(i_mode);
                    div_l_d   = i_div;
                    nsamp_l_d = i_nsamp;
                    div_cnt_d = '0;
                    cnt_d     = '0;
                    lfsr_d    = LFSR_SEED;
                    stop_d    = 1'b0;
                end
            end
            S_RUN: begin
                // A sampled stop suppresses strobes immediately and ends the burst
                // one edge later, mirroring the normal end-of-burst timing.
                if (cnt_q == nsamp_l_q || stop_q) begin
                    state_d = S_DONE;
                end else if (i_stop) begin
                    stop_d = 1'b1;
                end else if (div_cnt_q == div_l_q) begin
                    en_d      = 1'b1;
                    data_d    = sample_val;
                    cnt_d     = cnt_q + NB_CNT'(1);
                    div_cnt_d = '0;
                    lfsr_d    = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
                end else begin
                    div_cnt_d = div_cnt_q + NB_DIV'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign o_data = data_q;
    assign o_en   = en_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed bench for fir_stim_gen: every edge after a start is compared against
// hand-derived {en, busy, done, data} values.
module tb_fir_stim_gen;

    localparam int unsigned NB_DATA  = 8;
    localparam int unsigned NBF_DATA = 7;
    localparam int unsigned NB_DIV   = 8;
    localparam int unsigned NB_CNT   = 16;

    logic                clk = 1'b0;
    logic                i_rst_n;
    logic                i_start;
    logic                i_stop;
    logic [1:0]          i_mode;
    logic [NB_DIV-1:0]   i_div;
    logic [NB_CNT-1:0]   i_nsamp;
    logic [NB_DATA-1:0]  o_data;
    logic                o_en;
    logic                o_busy;
    logic                o_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_stim_gen #(
        .NB_DATA (NB_DATA),
        .NBF_DATA(NBF_DATA),
        .NB_DIV  (NB_DIV),
        .NB_CNT  (NB_CNT)
    ) dut (
        .clk    (clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_stop (i_stop),
        .i_mode (i_mode),
        .i_div  (i_div),
        .i_nsamp(i_nsamp),
        .o_data (o_data),
        .o_en   (o_en),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start pulse sampled at the next edge (E0), then scrambles the
    // configuration inputs so that only the latched values can matter.
    task automatic start_burst(input logic [1:0] mode, input logic [7:0] div,
                               input logic [15:0] n);
        i_mode  = mode;
        i_div   = div;
        i_nsamp = n;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_mode  = ~mode;
        i_div   = div + 8'd5;
        i_nsamp = n + 16'd3;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_mode  = 2'd0;
        i_div   = '0;
        i_nsamp = '0;
        #2;
        got = {o_en, o_busy, o_done, o_data};
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL reset_initial: en/busy/done/data got %b/%b/%b/%h expected 0/0/0/00",
                     got[10], got[9], got[8], got[7:0]);
        end
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        start_burst(2'd1, 8'd3, 16'd10);
        for (int e = 1; e <= 4; e++) tick();
        got = {o_en, o_busy, o_done, o_data};
        checks++;
        if (got !== {1'b1, 1'b1, 1'b0, 8'h7F}) begin
            errors++;
            $display("FAIL reset_pre_strobe: en/busy/done/data got %b/%b/%b/%h expected 1/1/0/7f",
                     got[10], got[9], got[8], got[7:0]);
        end
        #3;
        i_rst_n = 1'b0;
        #1;
        got = {o_en, o_busy, o_done, o_data};
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: en/busy/done/data got %b/%b/%b/%h expected 0/0/0/00",
                     got[10], got[9], got[8], got[7:0]);
        end
        tick();
        i_rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            got = {o_en, o_busy, o_done, o_data};
            checks++;
            if (got !== 11'd0) begin
                errors++;
                $display("FAIL reset_after_release E%0d: en/busy/done/data got %b/%b/%b/%h expected 0/0/0/00",
                         e, got[10], got[9], got[8], got[7:0]);
            end
        end
    endtask

    task automatic test_impulse();
        logic [10:0] got, exp;
        start_burst(2'd0, 8'd0, 16'd4);
        got = {o_en, o_busy, o_done, o_data};
        checks++;
        if (got !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL impulse E0: en/busy/done/data got %b/%b/%b/%h expected 0/1/0/00",
                     got[10], got[9], got[8], got[7:0]);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = {(e <= 4) ? 1'b1 : 1'b0, (e <= 4) ? 1'b1 : 1'b0,
                   (e == 5) ? 1'b1 : 1'b0, (e == 1) ? 8'h7F : 8'h00};
            got = {o_en, o_busy, o_done, o_data};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL impulse E%0d: en/busy/done/data got %b/%b/%b/%h expected %b/%b/%b/%h",
                         e, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_prbs();
        logic [10:0] got, exp;
        logic [7:0]  prbs [0:6];
        logic [7:0]  held;
        logic        en;
        prbs = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC1};
        held = 8'h00;
        start_burst(2'd2, 8'd2, 16'd7);
        for (int e = 1; e <= 23; e++) begin
            tick();
            en = (e % 3 == 0) && (e <= 21);
            if (en) held = prbs[e / 3 - 1];
            exp = {en, (e <= 21) ? 1'b1 : 1'b0, (e == 22) ? 1'b1 : 1'b0, held};
            got = {o_en, o_busy, o_done, o_data};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL prbs E%0d: en/busy/done/data got %b/%b/%b/%h expected %b/%b/%b/%h",
                         e, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_alt_stop();
        logic [10:0] got, exp;
        logic [7:0]  held;
        start_burst(2'd3, 8'd1, 16'd100);
        for (int e = 1; e <= 8; e++) begin
            i_stop = (e == 6);
            tick();
            held = (e >= 4) ? 8'hC0 : (e >= 2) ? 8'h40 : 8'hC1;
            exp = {(e == 2 || e == 4) ? 1'b1 : 1'b0, (e <= 6) ? 1'b1 : 1'b0,
                   (e == 7) ? 1'b1 : 1'b0, held};
            got = {o_en, o_busy, o_done, o_data};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL alt_stop E%0d: en/busy/done/data got %b/%b/%b/%h expected %b/%b/%b/%h",
                         e, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
        i_stop = 1'b0;
    endtask

    task automatic test_nsamp_zero();
        logic [10:0] got, exp;
        start_burst(2'd1, 8'd3, 16'd0);
        for (int e = 1; e <= 3; e++) begin
            i_stop = (e == 3);
            tick();
            exp = {1'b0, 1'b0, (e == 1) ? 1'b1 : 1'b0, 8'hC0};
            got = {o_en, o_busy, o_done, o_data};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL nsamp_zero E%0d: en/busy/done/data got %b/%b/%b/%h expected %b/%b/%b/%h",
                         e, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
        i_stop = 1'b0;
    endtask

    task automatic test_restart_ignored();
        logic [10:0] got, exp;
        start_burst(2'd1, 8'd0, 16'd3);
        for (int e = 1; e <= 5; e++) begin
            i_start = (e <= 2);
            i_nsamp = 16'd10;
            tick();
            exp = {(e <= 3) ? 1'b1 : 1'b0, (e <= 3) ? 1'b1 : 1'b0,
                   (e == 4) ? 1'b1 : 1'b0, 8'h7F};
            got = {o_en, o_busy, o_done, o_data};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL restart_ignored E%0d: en/busy/done/data got %b/%b/%b/%h expected %b/%b/%b/%h",
                         e, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
        i_start = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [10:0] got, exp;
        logic [7:0]  prbs [0:2];
        logic [7:0]  held;
        prbs = '{8'hFF, 8'hFE, 8'hFC};
        held = 8'h7F;
        for (int b = 0; b < 2; b++) begin
            start_burst(2'd2, 8'd0, 16'd3);
            got = {o_en, o_busy, o_done, o_data};
            checks++;
            if (got !== {1'b0, 1'b1, 1'b0, held}) begin
                errors++;
                $display("FAIL back_to_back b%0d E0: en/busy/done/data got %b/%b/%b/%h expected 0/1/0/%h",
                         b, got[10], got[9], got[8], got[7:0], held);
            end
            for (int e = 1; e <= 5; e++) begin
                tick();
                if (e <= 3) held = prbs[e - 1];
                exp = {(e <= 3) ? 1'b1 : 1'b0, (e <= 3) ? 1'b1 : 1'b0,
                       (e == 4) ? 1'b1 : 1'b0, held};
                got = {o_en, o_busy, o_done, o_data};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL back_to_back b%0d E%0d: en/busy/done/data got %b/%b/%b/%h expected %b/%b/%b/%h",
                             b, e, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_prbs();
        test_alt_stop();
        test_nsamp_zero();
        test_restart_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
